// File: rtl/sat_pkg.sv
// Shared types and sizing for the unit-clause register and its picker.
package sat_pkg;
  localparam int W = 8;

  // Keeps the index at least one bit wide when there is a single variable.
  function automatic int vw_of(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  localparam int VW = vw_of(W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    OFFER = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } picker_state_t;
endpackage

// File: rtl/lsb_priority_enc.sv
// Find-first-set: index of the lowest set bit of req, plus an any-set flag.
module lsb_priority_enc #(
  parameter int W  = 8,
  parameter int VW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  output logic [VW-1:0] idx,
  output logic          any
);
  // Walk from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VW'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/unit_clause_picker.sv
// Drains the unit-clause mask lowest index first: offers each unit variable with
// its forced value, clears it in the register, and pulses done once the mask is empty.
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | pick lowest pending variable, or finish if mask empty
//   OFFER | out_valid high, waiting for out_ready
//   CLEAR | one-cycle rw_en strobe to clear the accepted variable
//   DONE  | one-cycle done pulse
module unit_clause_picker
  import sat_pkg::*;
#(
  parameter int W  = sat_pkg::W,
  parameter int VW = vw_of(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  unit_clause,
  input  logic [W-1:0]  unit_pol,
  output logic          rw_en,
  output logic [VW-1:0] delete_var,
  output logic          out_valid,
  output logic [VW-1:0] out_var,
  output logic          out_val,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [VW:0]   prop_cnt
);
  picker_state_t state_q, state_d;
  logic [VW-1:0] var_q;
  logic          val_q;
  logic [VW:0]   prop_cnt_q;
  logic [VW-1:0] enc_idx;
  logic          enc_any;

  lsb_priority_enc #(.W(W), .VW(VW)) u_enc (
    .req (unit_clause),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    state_d = enc_any ? OFFER : DONE;
      OFFER:   if (out_ready) state_d = CLEAR;
      CLEAR:   state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      var_q      <= '0;
      val_q      <= 1'b0;
      prop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SCAN && enc_any && !abort) begin
        var_q <= enc_idx;
        val_q <= unit_pol[enc_idx];
      end
      if (state_q == IDLE && start && !abort) begin
        prop_cnt_q <= '0;
      end else if (state_q == OFFER && out_ready && !abort && prop_cnt_q != '1) begin
        prop_cnt_q <= prop_cnt_q + 1'b1;
      end
    end
  end

  // An abort landing in CLEAR suppresses the strobe so the pending bit survives.
  assign rw_en      = (state_q == CLEAR) && !abort;
  assign delete_var = var_q;
  assign out_valid  = (state_q == OFFER);
  assign out_var    = var_q;
  assign out_val    = val_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign prop_cnt   = prop_cnt_q;
endmodule

// File: tb/tb_unit_clause_picker.sv
// Bench for unit_clause_picker: models the unit-clause register and predicts the
// offer sequence directly from the mask and polarity bits.
module tb_unit_clause_picker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, out_ready;
  logic [7:0] mask, pol;
  logic       rw_en, out_valid, out_val, busy, done;
  logic [2:0] delete_var, out_var;
  logic [3:0] prop_cnt;

  int total = 0;
  int bad   = 0;
  int last_stalls;
  bit ok;

  unit_clause_picker #(.W(8), .VW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .unit_clause (mask),
    .unit_pol    (pol),
    .rw_en       (rw_en),
    .delete_var  (delete_var),
    .out_valid   (out_valid),
    .out_var     (out_var),
    .out_val     (out_val),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .prop_cnt    (prop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
  endtask

  // One full run; the register model clears a bit on every observed rw_en.
  task automatic run(input logic [7:0] m, input logic [7:0] p, input int rdy_pct, input int lowfor);
    int exp_vars[$];
    int got_var[$];
    int got_val[$];
    int del_q[$];
    int first_valid = -1;
    int done_cyc = -1;
    int last_acc = -100;
    int nvalid = 0;
    int stalls = 0;
    bit held = 1'b0;
    logic [2:0] hv;
    logic hb;
    bit rw_s;
    logic [2:0] del_s;
    mask = m;
    pol  = p;
    for (int i = 0; i < 8; i++) if (m[i]) exp_vars.push_back(i);
    pulse_start();
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      rw_s  = rw_en;
      del_s = delete_var;
      if (done) done_cyc = c;
      if (rw_s) begin
        del_q.push_back(int'(del_s));
        chk("rw_after_accept", got_var.size() >= del_q.size(), 1);
      end
      out_ready = 1'b0;
      if (out_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = c;
        if (held) begin
          chk("hold_var", out_var, hv);
          chk("hold_val", out_val, hb);
        end
        if (nvalid > lowfor && int'($urandom_range(99)) < rdy_pct) begin
          out_ready = 1'b1;
          if (got_var.size() > 0) chk("offer_gap_ge3", (c - last_acc) >= 3, 1);
          last_acc = c;
          got_var.push_back(int'(out_var));
          got_val.push_back(int'(out_val));
          held = 1'b0;
        end else begin
          stalls++;
          held = 1'b1;
          hv = out_var;
          hb = out_val;
        end
      end
      @(posedge clk);
      #1;
      if (rw_s) mask[del_s] = 1'b0;
    end
    out_ready = 1'b0;
    last_stalls = stalls;
    chk("done_seen", done_cyc > 0, 1);
    chk("n_offers", got_var.size(), exp_vars.size());
    chk("n_clears", del_q.size(), exp_vars.size());
    for (int i = 0; i < exp_vars.size() && i < got_var.size(); i++) begin
      chk("offer_var", got_var[i], exp_vars[i]);
      chk("offer_val", got_val[i], int'(p[exp_vars[i]]));
    end
    for (int i = 0; i < exp_vars.size() && i < del_q.size(); i++)
      chk("delete_var", del_q[i], exp_vars[i]);
    if (exp_vars.size() == 0) begin
      chk("empty_done_latency", done_cyc, 2);
      chk("empty_no_valid", first_valid, -1);
    end else begin
      chk("first_valid_latency", first_valid, 2);
    end
    chk("mask_drained", mask, 0);
    @(negedge clk);
    chk("prop_cnt", prop_cnt, exp_vars.size());
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    mask = 8'h00;
    pol = 8'h00;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rw_en", rw_en, 0);
    chk("rst_prop_cnt", prop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'b0010_0100, 8'hFF, 100, 0);
    run(8'h00, 8'hFF, 100, 0);
    run(8'h80, 8'h80, 100, 4);
    chk("stall_cycles", last_stalls, 4);
    run(8'hFF, 8'hA5, 100, 0);

    // Abort while the clear strobe is due.
    mask = 8'h01;
    pol  = 8'h00;
    pulse_start();
    wait_valid(10, ok);
    chk("abort_offer_seen", ok, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_rw_blocked", rw_en, 0);
    chk("abort_busy_before", busy, 1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_no_rw", rw_en, 0);
    chk("abort_no_done", done, 0);
    chk("abort_no_valid", out_valid, 0);
    run(8'h01, 8'h01, 100, 0);

    // Reset in the middle of the second offer.
    mask = 8'h0C;
    pol  = 8'h08;
    pulse_start();
    wait_valid(10, ok);
    chk("rst_first_offer", ok, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("rst_clear_rw", rw_en, 1);
    chk("rst_clear_idx", delete_var, 2);
    @(posedge clk);
    #1 mask[2] = 1'b0;
    wait_valid(10, ok);
    chk("rst_second_offer", ok, 1);
    chk("rst_second_var", out_var, 3);
    chk("rst_second_val", out_val, 1);
    chk("rst_cnt_before", prop_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_var", out_var, 0);
    chk("async_val", out_val, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", prop_cnt, 0);
    chk("async_rw", rw_en, 0);
    chk("async_del", delete_var, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h0C, 8'h08, 100, 0);

    for (int k = 0; k < 8; k++)
      run(8'($urandom), 8'($urandom), 60, int'($urandom_range(2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
